// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles nibbles into bytes and packs them into OUT_BYTES-wide beats.
// Optional FCS check (CRC-32 residue, crc_ok output) is compiled in when MII_RX_CRC_EN is defined.
module mii_rx_framer #(
  parameter int OUT_BYTES   = 4,
  parameter int MAX_LEN     = 1522,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                   mii_clk,
  input  logic                   reset,
  input  logic                   mii_en,
  input  logic                   mii_er,
  input  logic [3:0]             mii_d,
  output logic                   out_valid,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   out_err,
`ifdef MII_RX_CRC_EN
  output logic                   crc_ok,
`endif
  output logic [15:0]            frame_len
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam int                   W         = 8 * OUT_BYTES;
  localparam logic [15:0]          MAX_LEN16 = 16'(MAX_LEN);
  localparam logic [2:0]           LAST_LANE = 3'(OUT_BYTES - 1);
  localparam logic [OUT_BYTES-1:0] KEEP_ALL  = {OUT_BYTES{1'b1}};

  logic [1:0]           state_q, state_d;
  logic                 phase_q, phase_d;
  logic [3:0]           lo_q, lo_d;
  logic [2:0]           lane_q, lane_d;
  logic [W-1:0]         word_q, word_d;
  logic [W-1:0]         hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [15:0]          byte_cnt_q, byte_cnt_d;
  logic                 err_q, err_d;
  logic                 sof_pend_q, sof_pend_d;

  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic [OUT_BYTES-1:0] out_keep_q, out_keep_d;
  logic                 out_sof_q, out_sof_d;
  logic                 out_eof_q, out_eof_d;
  logic                 out_err_q, out_err_d;
  logic [15:0]          frame_len_q, frame_len_d;

  logic [3:0]           nib;
  logic [7:0]           rx_byte;
  logic                 err_now;
  logic [W-1:0]         eof_data;
  logic [OUT_BYTES-1:0] eof_keep;
  logic                 fcs_bad;

  function automatic logic [OUT_BYTES-1:0] keep_mask(input logic [2:0] n);
    logic [OUT_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < OUT_BYTES; i++) m[i] = (3'(i) < n);
    return m;
  endfunction

`ifdef MII_RX_CRC_EN
  logic [31:0] crc_q, crc_d;
  logic        crc_ok_q, crc_ok_d;
  logic        crc_good;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  // The register shifts LSB-first, so compare its bit-reversed image to the MSB-first residue.
  assign crc_good = (rev32(crc_q) == 32'hC704DD7B);
  assign fcs_bad  = ~crc_good;
`else
  assign fcs_bad  = 1'b0;
`endif

  assign nib      = BIT_REVERSE ? {mii_d[0], mii_d[1], mii_d[2], mii_d[3]} : mii_d;
  assign rx_byte  = {nib, lo_q};
  assign err_now  = err_q | mii_er;
  assign eof_data = hold_vld_q ? hold_q : word_q;
  assign eof_keep = hold_vld_q ? KEEP_ALL : keep_mask(lane_q);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    lo_d        = lo_q;
    lane_d      = lane_q;
    word_d      = word_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    byte_cnt_d  = byte_cnt_q;
    err_d       = err_q;
    sof_pend_d  = sof_pend_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_keep_d  = '0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    out_err_d   = 1'b0;
    frame_len_d = '0;
`ifdef MII_RX_CRC_EN
    crc_d       = crc_q;
    crc_ok_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mii_en) state_d = (mii_d == 4'h5) ? ST_PRE : ST_DROP;
      end
      ST_PRE: begin
        if (!mii_en) begin
          state_d = ST_IDLE;
        end else if (mii_d == 4'hD) begin
          state_d    = ST_DATA;
          phase_d    = 1'b0;
          lane_d     = '0;
          word_d     = '0;
          hold_vld_d = 1'b0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
          sof_pend_d = 1'b1;
`ifdef MII_RX_CRC_EN
          crc_d      = 32'hFFFFFFFF;
`endif
        end else if (mii_d != 4'h5) begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        err_d = err_now;
        if (!mii_en) begin
          state_d    = ST_IDLE;
          hold_vld_d = 1'b0;
          if (byte_cnt_q != 16'd0) begin
            out_valid_d = 1'b1;
            out_eof_d   = 1'b1;
            out_sof_d   = sof_pend_q;
            out_data_d  = eof_data;
            out_keep_d  = eof_keep;
            out_err_d   = err_now | phase_q | fcs_bad;
            frame_len_d = byte_cnt_q;
            sof_pend_d  = 1'b0;
`ifdef MII_RX_CRC_EN
            crc_ok_d    = crc_good;
`endif
          end
        end else if (!phase_q) begin
          lo_d    = nib;
          phase_d = 1'b1;
          // At MAX_LEN the held word stays put: it becomes the EOF beat either way.
          if (hold_vld_q && byte_cnt_q != MAX_LEN16) begin
            out_valid_d = 1'b1;
            out_sof_d   = sof_pend_q;
            out_data_d  = hold_q;
            out_keep_d  = KEEP_ALL;
            hold_vld_d  = 1'b0;
            sof_pend_d  = 1'b0;
          end
        end else begin
          phase_d = 1'b0;
          if (byte_cnt_q == MAX_LEN16) begin
            state_d     = ST_DROP;
            out_valid_d = 1'b1;
            out_eof_d   = 1'b1;
            out_err_d   = 1'b1;
            out_sof_d   = sof_pend_q;
            out_data_d  = eof_data;
            out_keep_d  = eof_keep;
            frame_len_d = MAX_LEN16;
            hold_vld_d  = 1'b0;
            sof_pend_d  = 1'b0;
          end else begin
            byte_cnt_d = byte_cnt_q + 16'd1;
`ifdef MII_RX_CRC_EN
            crc_d      = crc_byte(crc_q, rx_byte);
`endif
            for (int i = 0; i < OUT_BYTES; i++) begin
              if (lane_q == 3'(i)) word_d[8*i +: 8] = rx_byte;
            end
            if (lane_q == LAST_LANE) begin
              hold_d     = word_d;
              hold_vld_d = 1'b1;
              word_d     = '0;
              lane_d     = '0;
            end else begin
              lane_d = lane_q + 3'd1;
            end
          end
        end
      end
      default: begin
        if (!mii_en) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge mii_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      lo_q        <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
      sof_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      frame_len_q <= '0;
`ifdef MII_RX_CRC_EN
      crc_q       <= 32'hFFFFFFFF;
      crc_ok_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      lo_q        <= lo_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
      sof_pend_q  <= sof_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      frame_len_q <= frame_len_d;
`ifdef MII_RX_CRC_EN
      crc_q       <= crc_d;
      crc_ok_q    <= crc_ok_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_err   = out_err_q;
  assign frame_len = frame_len_q;
`ifdef MII_RX_CRC_EN
  assign crc_ok    = crc_ok_q;
`endif

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer (OUT_BYTES=4, MAX_LEN=8, BIT_REVERSE=1) with a beat scoreboard.
// Frames are modelled as byte lists; expected beats are derived from the byte list alone.
module tb_mii_rx_framer;

  localparam int OB   = 4;
  localparam int MAXL = 8;

  logic        mii_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        mii_en  = 1'b0;
  logic        mii_er  = 1'b0;
  logic [3:0]  mii_d   = 4'h0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [15:0] frame_len;
`ifdef MII_RX_CRC_EN
  logic        crc_ok;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        sof;
    logic        eof;
    logic        err;
    logic        crc;
    logic [15:0] len;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] frame_q[$];
  logic       prev_valid = 1'b0;

  always #5 mii_clk = ~mii_clk;

  mii_rx_framer #(.OUT_BYTES(OB), .MAX_LEN(MAXL), .BIT_REVERSE(1'b1)) dut (
    .mii_clk   (mii_clk),
    .reset     (reset),
    .mii_en    (mii_en),
    .mii_er    (mii_er),
    .mii_d     (mii_d),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_err   (out_err),
`ifdef MII_RX_CRC_EN
    .crc_ok    (crc_ok),
`endif
    .frame_len (frame_len)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] enc(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Model: expected beats for the bytes in frame_q.
  task automatic push_expected(input bit had_er, input bit odd);
    int          n;
    int          eff;
    int          nb;
    bit          trunc;
    bit          crc_good;
    logic [31:0] c;
    beat_t       e;
    n     = frame_q.size();
    trunc = (n > MAXL);
    eff   = trunc ? MAXL : n;
    c     = 32'hFFFFFFFF;
    for (int i = 0; i < eff; i++) c = crc_upd(c, frame_q[i]);
    crc_good = (c == 32'hDEBB20E3) && !trunc;
    nb = (eff + OB - 1) / OB;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      e.keep = '0;
      for (int l = 0; l < OB; l++) begin
        if (b*OB + l < eff) begin
          e.data[l*8 +: 8] = frame_q[b*OB + l];
          e.keep[l]        = 1'b1;
        end
      end
      e.sof = (b == 0);
      e.eof = (b == nb - 1);
      e.err = e.eof && (had_er || odd || trunc);
`ifdef MII_RX_CRC_EN
      e.err = e.err || (e.eof && !crc_good);
      e.crc = e.eof && crc_good;
`else
      e.crc = 1'b0;
`endif
      e.len = e.eof ? 16'(eff) : 16'd0;
      sb.push_back(e);
    end
  endtask

  task automatic drive(input logic en, input logic er, input logic [3:0] d);
    @(negedge mii_clk);
    mii_en = en;
    mii_er = er;
    mii_d  = d;
  endtask

  task automatic send_frame(input int er_byte, input bit odd, input int gap);
    push_expected(er_byte >= 0, odd);
    repeat (15) drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < frame_q.size(); i++) begin
      drive(1'b1, (i == er_byte), enc(frame_q[i][3:0]));
      drive(1'b1, 1'b0, enc(frame_q[i][7:4]));
    end
    if (odd) drive(1'b1, 1'b0, enc(4'hA));
    repeat (gap) drive(1'b0, 1'b0, 4'h0);
  endtask

  task automatic load(input int n, input logic [7:0] base);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(base + 8'(i));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge mii_clk);
      n++;
    end
    repeat (4) @(negedge mii_clk);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge mii_clk) begin
    beat_t e;
    if (out_valid) begin
      chk("valid_back_to_back", 64'(prev_valid), 64'd0);
      chk("beat_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data", 64'(out_data & {{8{e.keep[3]}}, {8{e.keep[2]}}, {8{e.keep[1]}}, {8{e.keep[0]}}}), 64'(e.data));
        chk("keep", 64'(out_keep), 64'(e.keep));
        chk("sof", 64'(out_sof), 64'(e.sof));
        chk("eof", 64'(out_eof), 64'(e.eof));
        if (e.eof) begin
          chk("err", 64'(out_err), 64'(e.err));
          chk("frame_len", 64'(frame_len), 64'(e.len));
`ifdef MII_RX_CRC_EN
          chk("crc_ok", 64'(crc_ok), 64'(e.crc));
`endif
        end
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    logic [31:0] c;

    // Reset state
    repeat (3) @(negedge mii_clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_keep", 64'(out_keep), 64'd0);
    chk("rst_sof", 64'(out_sof), 64'd0);
    chk("rst_eof", 64'(out_eof), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_len", 64'(frame_len), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge mii_clk);

    // Two full words
    load(8, 8'h01);
    send_frame(-1, 1'b0, 2);
    drain("t1_drain");

    // Five bytes: partial last word
    load(5, 8'h11);
    send_frame(-1, 1'b0, 2);
    drain("t2_drain");

    // Exactly one word: held word becomes the EOF beat
    load(4, 8'hA0);
    send_frame(-1, 1'b0, 2);
    drain("t_oneword_drain");

    // RX_ER during byte 3, then clean frame after a one-cycle gap
    load(6, 8'h21);
    send_frame(2, 1'b0, 1);
    load(6, 8'h31);
    send_frame(-1, 1'b0, 2);
    drain("t3_drain");

    // Dribble nibble
    load(3, 8'h41);
    send_frame(-1, 1'b1, 2);
    drain("t4_drain");

    // Bad preamble 5,5,3: nothing comes out
    drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'h3);
    repeat (6) drive(1'b1, 1'b0, enc(4'h7));
    drive(1'b0, 1'b0, 4'h0);
    drain("t4_badpre_drain");

    // Zero data bytes plus one stray nibble: nothing comes out
    frame_q.delete();
    send_frame(-1, 1'b1, 2);
    drain("t4_empty_drain");

    // Truncation at MAX_LEN
    load(12, 8'h51);
    send_frame(-1, 1'b0, 2);
    drain("t5_drain");

    // Reset in the middle of DATA
    repeat (15) drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, enc(4'h6));
      drive(1'b1, 1'b0, enc(4'h9));
    end
    @(negedge mii_clk);
    reset  = 1'b1;
    mii_en = 1'b0;
    @(negedge mii_clk);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_eof", 64'(out_eof), 64'd0);
    chk("t6_data", 64'(out_data), 64'd0);
    @(negedge mii_clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0);
    drain("t6_noeof");
    load(8, 8'h61);
    send_frame(-1, 1'b0, 2);
    drain("t6_after_drain");

`ifdef MII_RX_CRC_EN
    // Good FCS, then the same frame with one bit flipped
    load(4, 8'hC1);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) c = crc_upd(c, frame_q[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frame_q.push_back(c[8*i +: 8]);
    send_frame(-1, 1'b0, 2);
    drain("crc_good_drain");
    frame_q[1] = frame_q[1] ^ 8'h04;
    send_frame(-1, 1'b0, 2);
    drain("crc_bad_drain");
`else
    c = 32'h0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
